// File: rtl/alu_pkg.sv
// Shared definitions for the ALU UART front-end: default widths, opcodes,
// and the sequencer state encoding.
package alu_pkg;

  localparam int NB_DATA_DEF   = 8;
  localparam int NB_OPCODE_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam logic [2:0] ST_WAIT_OPE1 = 3'd0;
  localparam logic [2:0] ST_WAIT_OPE2 = 3'd1;
  localparam logic [2:0] ST_WAIT_OP   = 3'd2;
  localparam logic [2:0] ST_EXEC      = 3'd3;
  localparam logic [2:0] ST_SEND      = 3'd4;
  localparam logic [2:0] ST_WAIT_TX   = 3'd5;

endpackage

// File: rtl/opcode_valid_chk.sv
// Flags whether a received byte is one of the eight supported ALU opcodes
// (top two bits must be zero).
module opcode_valid_chk
  import alu_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_valid
);

  always_comb begin
    o_valid = 1'b0;
    if (i_byte[7:6] == 2'b00) begin
      case (i_byte[5:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SRA, OP_SRL, OP_NOR: o_valid = 1'b1;
        default:                        o_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_uart_if.sv
// Collects operand/operand/opcode bytes from the UART, commits them to the
// ALU atomically, and hands the result back to the UART transmitter.
//
// state     | meaning
// WAIT_OPE1 | waiting for operand 1 byte
// WAIT_OPE2 | waiting for operand 2 byte
// WAIT_OP   | waiting for opcode byte; commit or discard frame
// EXEC      | ALU settling; capture result
// SEND      | pulse tx start
// WAIT_TX   | waiting for transmitter to finish
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF,
  parameter int NB_COUNT  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_ope1,
  output logic [NB_DATA-1:0]   o_ope2,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_err_opcode,
  output logic                 o_overrun,
  output logic [NB_COUNT-1:0]  o_frame_count
);

  logic [2:0]           state_q, state_d;
  logic [NB_DATA-1:0]   shadow1_q, shadow1_d;
  logic [NB_DATA-1:0]   shadow2_q, shadow2_d;
  logic [NB_DATA-1:0]   ope1_q, ope1_d;
  logic [NB_DATA-1:0]   ope2_q, ope2_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 err_q, err_d;
  logic                 ovr_q, ovr_d;
  logic [NB_COUNT-1:0]  count_q, count_d;
  logic                 op_valid;

  opcode_valid_chk u_opcode_valid_chk (
    .i_byte  (i_rx_data[7:0]),
    .o_valid (op_valid)
  );

  always_comb begin
    state_d   = state_q;
    shadow1_d = shadow1_q;
    shadow2_d = shadow2_q;
    ope1_d    = ope1_q;
    ope2_d    = ope2_q;
    opcode_d  = opcode_q;
    tx_data_d = tx_data_q;
    count_d   = count_q;
    err_d     = 1'b0;
    ovr_d     = 1'b0;
    case (state_q)
      ST_WAIT_OPE1: if (i_rx_done) begin
        shadow1_d = i_rx_data;
        state_d   = ST_WAIT_OPE2;
      end
      ST_WAIT_OPE2: if (i_rx_done) begin
        shadow2_d = i_rx_data;
        state_d   = ST_WAIT_OP;
      end
      ST_WAIT_OP: if (i_rx_done) begin
        if (op_valid) begin
          ope1_d   = shadow1_q;
          ope2_d   = shadow2_q;
          opcode_d = i_rx_data[NB_OPCODE-1:0];
          state_d  = ST_EXEC;
        end else begin
          err_d   = 1'b1;
          state_d = ST_WAIT_OPE1;
        end
      end
      ST_EXEC: begin
        tx_data_d = i_alu_result;
        ovr_d     = i_rx_done;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        ovr_d   = i_rx_done;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          count_d = count_q + NB_COUNT'(1);
          state_d = ST_WAIT_OPE1;
          // A byte landing with the tx completion starts the next frame.
          if (i_rx_done) begin
            shadow1_d = i_rx_data;
            state_d   = ST_WAIT_OPE2;
          end
        end else begin
          ovr_d = i_rx_done;
        end
      end
      default: state_d = ST_WAIT_OPE1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_WAIT_OPE1;
      shadow1_q <= '0;
      shadow2_q <= '0;
      ope1_q    <= '0;
      ope2_q    <= '0;
      opcode_q  <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shadow1_q <= shadow1_d;
      shadow2_q <= shadow2_d;
      ope1_q    <= ope1_d;
      ope2_q    <= ope2_d;
      opcode_q  <= opcode_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
      count_q   <= count_d;
    end
  end

  assign o_ope1        = ope1_q;
  assign o_ope2        = ope2_q;
  assign o_opcode      = opcode_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = (state_q == ST_SEND);
  assign o_err_opcode  = err_q;
  assign o_overrun     = ovr_q;
  assign o_frame_count = count_q;

endmodule

// File: doc/alu_uart_if.md
Name: alu_uart_if

Overview:
- Sequential front-end for the 8-bit ALU. Collects three bytes from the UART receiver (operand 1, operand 2, opcode), commits them together to the ALU inputs, captures the ALU result and hands it to the UART transmitter.
- Sits between uart_rx/uart_tx and the ALU. The ALU stays purely combinational; this block owns all sequencing.

Parameters:
- NB_DATA, 8, width of operands, result and UART bytes
- NB_OPCODE, 6, width of ALU opcode (low bits of third byte)
- NB_COUNT, 8, width of completed-frame counter

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  byte from UART receiver
- i_rx_done  in  1  one-cycle pulse, i_rx_data valid
- i_tx_done  in  1  one-cycle pulse, transmitter finished byte
- i_alu_result  in  NB_DATA  combinational result from ALU
- o_ope1  out  NB_DATA  operand 1 to ALU
- o_ope2  out  NB_DATA  operand 2 to ALU
- o_opcode  out  NB_OPCODE  opcode to ALU
- o_tx_data  out  NB_DATA  byte to UART transmitter
- o_tx_start  out  1  one-cycle pulse, start transmission
- o_err_opcode  out  1  one-cycle pulse, invalid opcode byte dropped
- o_overrun  out  1  one-cycle pulse, rx byte arrived while busy
- o_frame_count  out  NB_COUNT  completed frames, wraps modulo 2^NB_COUNT

Behaviour:
- Reset (i_reset low, asynchronous): state = WAIT_OPE1; all outputs, shadow registers and counter = 0.
- States: WAIT_OPE1, WAIT_OPE2, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_OPE1: on i_rx_done, shadow1 <= i_rx_data; go to WAIT_OPE2.
- WAIT_OPE2: on i_rx_done, shadow2 <= i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_done, check i_rx_data[7:6] == 2'b00 and i_rx_data[5:0] in {100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL, 100111 NOR}.
  - Valid: o_ope1 <= shadow1, o_ope2 <= shadow2, o_opcode <= i_rx_data[5:0], all in the same edge; go to EXEC.
  - Invalid: o_err_opcode pulses next cycle; ALU outputs unchanged; go to WAIT_OPE1 (whole frame discarded).
- EXEC: one cycle for the ALU to settle. o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start = 1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on i_tx_done, o_frame_count increments (wraps FF->00) and state goes to WAIT_OPE1.
- Latency: opcode i_rx_done at edge N -> ALU inputs valid after N -> o_tx_data loaded at N+1 -> o_tx_start high in cycle N+2.
- Rx bytes in EXEC, SEND or WAIT_TX are dropped and o_overrun pulses 1 cycle.
- Exception: i_rx_done coinciding with i_tx_done in WAIT_TX is accepted as operand 1 (shadow1 loaded, state goes to WAIT_OPE2); no overrun.
- i_tx_done outside WAIT_TX is ignored.
- o_ope1/o_ope2/o_opcode change only on a valid opcode commit. The ALU never sees a partial frame.
- Reset mid-frame or mid-transmission: immediate return to reset values; pending shadow bytes are lost.
- No timeout. A partial frame waits indefinitely.

Decomposition:
- Shared package alu_pkg: the eight opcode constants (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR), NB_DATA and NB_OPCODE defaults, and the state encoding localparams.
- One natural sub-module: opcode_valid_chk. It is combinational; it takes the 8-bit byte and returns the valid flag. It is reused by later decoder work.
- Everything else is flat in alu_uart_if.

Test Plan:
- Reset then bytes F1, F2, 20: ALU inputs F1/F2/100000 after 3rd byte; with ALU attached, o_tx_data = E3, o_tx_start one pulse 2 cycles after opcode pulse; i_tx_done -> o_frame_count = 01.
- Bytes 01, 0F, 22 (SUB) -> o_tx_data = F2. Bytes 01, 0F, 27 (NOR) -> F0. Bytes F1, F2, 24 (AND) -> F0.
- Bytes 11, 22, 3F: o_err_opcode single pulse; no o_tx_start; o_ope1/o_ope2/o_opcode keep previous frame values; next frame 01, 01, 20 -> o_tx_data = 02.
- Extra byte 55 sent during WAIT_TX -> o_overrun pulse, no state change. Byte 07 with same-cycle i_tx_done -> accepted as operand 1; frame 07, 01, 20 -> o_tx_data = 08.
- Assert i_reset low after 2 bytes, and again during WAIT_TX: all outputs return to 0 asynchronously (before next edge); state WAIT_OPE1; next full frame processes correctly.
- Run 256 valid frames -> o_frame_count wraps from FF to 00.
